booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Parametrised, sequential radix-4 Booth multiplier for the CPU datapath MUL path.
- Successor to the fixed 32-bit combinational Booth block.
- Generalised width; runtime signed/unsigned mode; one recoded digit per clock; start/busy/done handshake; registered result.
- Sits between the register-file read operands and the HI/LO result registers.

Parameters:
- WIDTH, 32, operand width; must be even and >= 4 (elaboration-time check).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned; sampled with start.
- multiplicand  input  WIDTH  operand M; sampled with start.
- multiplier  input  WIDTH  operand Q; sampled with start.
- busy  output  1  high while in CALC.
- done  output  1  single-cycle pulse; product is valid from this cycle on.
- product  output  2*WIDTH  registered result; held until the next completion.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; product=0; all internal registers cleared.
- Reset mid-operation aborts the operation with no partial result. Operation resumes normally after rst_n deasserts.
- Operand extension: both operands are extended to WIDTH+2 bits at capture. Extension is sign-extension if signed_mode=1, zero-extension if 0. The extended width makes unsigned full-range correct.
- Step count: N = WIDTH/2 + 1 (17 for WIDTH=32).
- States: IDLE, CALC, DONE.
- IDLE, start=0: remain in IDLE.
- IDLE, start=1, at edge E0:
  - capture the extended operands;
  - accumulator=0; multiplier shift register = extended Q; q_minus1=0; step counter=0;
  - next state CALC.
- CALC, one step per edge:
  - digit = {Q[1], Q[0], q_minus1};
  - 000/111 -> add 0; 001/010 -> add +M; 011 -> add +2M; 100 -> add -2M; 101/110 -> add -M;
  - M and 2M are taken from the extended multiplicand; the accumulator is WIDTH+4 bits signed, so ±2M never overflows;
  - then arithmetic shift {acc, Q, q_minus1} right by 2;
  - counter increments; after the Nth step, next state is DONE.
- DONE (exactly one cycle):
  - done=1; product = low 2*WIDTH bits of {acc, Q} after the final shift;
  - next state IDLE unconditionally.
- Latency: done asserted in cycle E0+N+1. For WIDTH=32 this is 18 cycles after the start edge; back-to-back throughput is one result per N+2 cycles.
- busy=1 exactly during the N CALC cycles.
- Ignored inputs:
  - start asserted in CALC or DONE is ignored (not queued);
  - changes to multiplicand/multiplier/signed_mode during CALC have no effect.
- product register: changes only at entry to DONE and is stable otherwise, including through IDLE and the next CALC.
- Wrap-around: none. The 2*WIDTH result is exact for all signed and unsigned operand pairs, including the most-negative value times itself.

Decomposition:
- Package booth_pkg:
  - state enum (IDLE, CALC, DONE);
  - Booth digit-select enum (ZERO, POS1, POS2, NEG1, NEG2);
  - localparam helper for step count N from WIDTH.
- Sub-module booth_r4_digit: combinational recoder. Takes the 3-bit digit plus the extended multiplicand and outputs the WIDTH+4-bit signed addend (0, ±M, ±2M). Instantiated once.
- Top: FSM, counter, shift registers, result register.

Test Plan:
- WIDTH=32, signed_mode=1, M=0xFFFFFFFD (-3), Q=0x00000007 -> product=0xFFFFFFFF_FFFFFFEB; done pulses exactly 18 cycles after start edge; busy high 17 cycles.
- WIDTH=32, signed_mode=0, M=Q=0xFFFFFFFF -> product=0xFFFFFFFE_00000001.
- WIDTH=32, signed_mode=1, M=Q=0x80000000 -> product=0x40000000_00000000. Same operands with signed_mode=0 -> 0x40000000_00000000.
- Start M=5, Q=6 signed. Mid-CALC, pulse start with M=9, Q=9 and change operands -> single done pulse, product=0x1E. A second done occurs only after a new start in IDLE.
- Assert rst_n=0 at cycle 8 of CALC -> busy, done and product go to 0 immediately (asynchronously). After release, start with M=2, Q=3 -> product=6 with normal latency.
- WIDTH=8 instance: M=0x80, Q=0x01, signed -> 0xFF80 with done 6 cycles after the start edge. Same operands unsigned -> 0x0080.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    D_ZERO = 3'd0,
    D_POS1 = 3'd1,
    D_POS2 = 3'd2,
    D_NEG1 = 3'd3,
    D_NEG2 = 3'd4
  } digit_sel_t;

  // One radix-4 digit per step over the WIDTH+2 extended multiplier.
  function automatic int unsigned booth_steps(input int unsigned w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_mul_seq_digit.sv
// Radix-4 Booth recoder: maps a 3-bit digit window to the addend 0, +-M or +-2M.
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       digit,
  input  logic [WIDTH+1:0] mcand,
  output logic [WIDTH+3:0] addend_c
);

  localparam int unsigned AW = WIDTH + 4;

  digit_sel_t      sel_c;
  logic [AW-1:0]   m1_c;
  logic [AW-1:0]   m2_c;

  assign m1_c = {{2{mcand[WIDTH+1]}}, mcand};
  assign m2_c = {m1_c[AW-2:0], 1'b0};

  // Digit decode.
  always_comb begin
    sel_c = D_ZERO;
    case (digit)
      3'b001, 3'b010: sel_c = D_POS1;
      3'b011:         sel_c = D_POS2;
      3'b100:         sel_c = D_NEG2;
      3'b101, 3'b110: sel_c = D_NEG1;
      default:        sel_c = D_ZERO;
    endcase
  end

  always_comb begin
    addend_c = '0;
    case (sel_c)
      D_POS1:  addend_c = m1_c;
      D_POS2:  addend_c = m2_c;
      D_NEG1:  addend_c = -m1_c;
      D_NEG2:  addend_c = -m2_c;
      default: addend_c = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed/unsigned at runtime.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned EW    = WIDTH + 2;
  localparam int unsigned AW    = WIDTH + 4;
  localparam int unsigned NSTEP = booth_steps(WIDTH);
  localparam int unsigned CW    = $clog2(NSTEP + 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("booth_mul_seq: WIDTH must be even and >= 4");
  end

  state_t          state;
  state_t          state_nxt;
  logic [EW-1:0]   mcand_q;
  logic [EW-1:0]   mq_q;
  logic [AW-1:0]   acc_q;
  logic            qm1_q;
  logic [CW-1:0]   cnt_q;

  logic [EW-1:0]   mcand_ext_c;
  logic [EW-1:0]   mplier_ext_c;
  logic [AW-1:0]   addend_c;
  logic [AW-1:0]   sum_c;
  logic [AW-1:0]   acc_sh_c;
  logic [EW-1:0]   mq_sh_c;
  logic            last_c;

  // Extension to WIDTH+2 keeps unsigned full-range operands positive.
  assign mcand_ext_c  = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                    : {2'b00, multiplicand};
  assign mplier_ext_c = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                    : {2'b00, multiplier};

  booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
    .digit    ({mq_q[1:0], qm1_q}),
    .mcand    (mcand_q),
    .addend_c (addend_c)
  );

  // Add then arithmetic shift of {acc, Q, q_minus1} by two.
  assign sum_c    = acc_q + addend_c;
  assign acc_sh_c = {{2{sum_c[AW-1]}}, sum_c[AW-1:2]};
  assign mq_sh_c  = {sum_c[1:0], mq_q[EW-1:2]};
  assign last_c   = (cnt_q == CW'(NSTEP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (last_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= (state_nxt == S_CALC);
      done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand_q <= mcand_ext_c;
            mq_q    <= mplier_ext_c;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_CALC: begin
          acc_q <= acc_sh_c;
          mq_q  <= mq_sh_c;
          qm1_q <= mq_q[1];
          cnt_q <= cnt_q + CW'(1);
          if (last_c) product <= {acc_sh_c[WIDTH-3:0], mq_sh_c};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed scoreboard bench for booth_mul_seq at WIDTH=32 and WIDTH=8.
module tb_booth_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start32, sm32;
  logic [31:0] m32, q32;
  logic        busy32, done32;
  logic [63:0] prod32;
  logic        start8, sm8;
  logic [7:0]  m8, q8;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic [63:0] sb32[$];
  logic [15:0] sb8[$];
  logic [63:0] last32;
  logic [15:0] last8;
  int          n_asserts;
  int          n_fail;
  int          extra;

  booth_mul_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(sm32),
    .multiplicand(m32), .multiplier(q32),
    .busy(busy32), .done(done32), .product(prod32)
  );

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run32(input logic sm, input logic [31:0] m, input logic [31:0] q,
                       input logic [63:0] exp, input bit disturb);
    int          cyc;
    int          busy_cnt;
    bit          seen;
    logic [63:0] e;
    @(negedge clk);
    start32 = 1'b1; sm32 = sm; m32 = m; q32 = q;
    sb32.push_back(exp);
    @(posedge clk); #1;
    start32 = 1'b0;
    cyc = 1; busy_cnt = 0; seen = 1'b0;
    check("hold32", prod32, last32);
    while (!seen && cyc <= 40) begin
      if (disturb && cyc == 5) begin
        start32 = 1'b1; m32 = 32'd9; q32 = 32'd9; sm32 = ~sm;
      end
      if (disturb && cyc == 6) start32 = 1'b0;
      if (busy32) busy_cnt++;
      if (done32) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("done32_seen", 64'(seen), 64'd1);
    check("lat32", 64'(cyc), 64'd18);
    check("busy32_cycles", 64'(busy_cnt), 64'd17);
    if (sb32.size() != 0) begin
      e = sb32.pop_front();
      if (seen) check("prod32", prod32, e);
      last32 = e;
    end
    @(posedge clk); #1;
    check("pulse32", 64'(done32), 64'd0);
    check("idle32", 64'(busy32), 64'd0);
  endtask

  task automatic run8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                      input logic [15:0] exp);
    int          cyc;
    int          busy_cnt;
    bit          seen;
    logic [15:0] e;
    @(negedge clk);
    start8 = 1'b1; sm8 = sm; m8 = m; q8 = q;
    sb8.push_back(exp);
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 1; busy_cnt = 0; seen = 1'b0;
    check("hold8", 64'(prod8), 64'(last8));
    while (!seen && cyc <= 20) begin
      if (busy8) busy_cnt++;
      if (done8) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("done8_seen", 64'(seen), 64'd1);
    check("lat8", 64'(cyc), 64'd6);
    check("busy8_cycles", 64'(busy_cnt), 64'd5);
    if (sb8.size() != 0) begin
      e = sb8.pop_front();
      if (seen) check("prod8", 64'(prod8), 64'(e));
      last8 = e;
    end
    @(posedge clk); #1;
    check("pulse8", 64'(done8), 64'd0);
  endtask

  initial begin
    n_asserts = 0; n_fail = 0; extra = 0;
    last32 = '0; last8 = '0;
    rst_n = 1'b0;
    start32 = 1'b0; sm32 = 1'b0; m32 = '0; q32 = '0;
    start8 = 1'b0;  sm8 = 1'b0;  m8 = '0;  q8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_prod32", prod32, 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_prod8", 64'(prod8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run32(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run32(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run32(1'b1, 32'd5, 32'd6, 64'h0000_0000_0000_001E, 1'b1);

    // The start pulse seen during CALC must not produce a second result.
    repeat (25) begin
      @(posedge clk); #1;
      if (done32) extra++;
    end
    check("no_second_done", 64'(extra), 64'd0);
    check("prod32_held", prod32, 64'h1E);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    start32 = 1'b1; sm32 = 1'b1; m32 = 32'h1234_5678; q32 = 32'h0FED_CBA9;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("busy_pre_rst", 64'(busy32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy32), 64'd0);
    check("abort_done", 64'(done32), 64'd0);
    check("abort_prod", prod32, 64'd0);
    last32 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run32(1'b1, 32'd2, 32'd3, 64'd6, 1'b0);

    run8(1'b1, 8'h80, 8'h01, 16'hFF80);
    run8(1'b0, 8'h80, 8'h01, 16'h0080);
    run8(1'b1, 8'hF9, 8'h7F, 16'hFC87);
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
